// File: rtl/ysyx_23060201_mem_arbiter_pkg.sv
// Shared encodings for the IFU/LSU memory arbiter: FSM states, owner codes, default widths.
// Build option MEM_ARB_RR_EN selects round-robin arbitration in the grant block.
package ysyx_23060201_mem_arbiter_pkg;

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_MASK_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    localparam logic OWNER_IFU = 1'b0;
    localparam logic OWNER_LSU = 1'b1;

    // Grant vector layout is {lsu, ifu}.
    function automatic logic [1:0] owner_to_onehot(input logic owner);
        return (owner == OWNER_LSU) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/ysyx_23060201_mem_arb_grant.sv
// Two-requester grant logic. Fixed LSU>IFU priority by default; with MEM_ARB_RR_EN defined,
// a last_grant register makes contended cycles alternate between the requesters.
module ysyx_23060201_mem_arb_grant
    import ysyx_23060201_mem_arbiter_pkg::*;
(
`ifdef MEM_ARB_RR_EN
    input  logic       clk,
    input  logic       rst,
    input  logic       accept_i,
`endif
    input  logic       ifu_req_i,
    input  logic       lsu_req_i,
    output logic [1:0] gnt_o,
    output logic       owner_o
);

    logic owner_d;

`ifdef MEM_ARB_RR_EN
    logic last_grant_q;

    // Starts at LSU so the first contended cycle favours the IFU.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= OWNER_LSU;
        end else if (accept_i) begin
            last_grant_q <= owner_d;
        end
    end

    always_comb begin
        owner_d = OWNER_IFU;
        if (ifu_req_i && lsu_req_i) begin
            owner_d = ~last_grant_q;
        end else if (lsu_req_i) begin
            owner_d = OWNER_LSU;
        end
    end
`else
    assign owner_d = lsu_req_i ? OWNER_LSU : OWNER_IFU;
`endif

    assign owner_o = owner_d;
    assign gnt_o   = (ifu_req_i || lsu_req_i) ? owner_to_onehot(owner_d) : 2'b00;

endmodule

// File: rtl/ysyx_23060201_mem_arbiter.sv
// Serialises IFU fetches and LSU loads/stores onto one memory port, one transaction at a time.
// Define MEM_ARB_RR_EN for round-robin arbitration instead of fixed LSU>IFU priority.
module ysyx_23060201_mem_arbiter
    import ysyx_23060201_mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MASK_WIDTH = DEF_MASK_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ifu_req_valid,
    output logic                  ifu_req_ready,
    input  logic [ADDR_WIDTH-1:0] ifu_req_addr,
    output logic                  ifu_resp_valid,
    input  logic                  ifu_resp_ready,
    output logic [DATA_WIDTH-1:0] ifu_resp_data,
    input  logic                  lsu_req_valid,
    output logic                  lsu_req_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_req_addr,
    input  logic                  lsu_req_wen,
    input  logic [DATA_WIDTH-1:0] lsu_req_wdata,
    input  logic [MASK_WIDTH-1:0] lsu_req_wmask,
    output logic                  lsu_resp_valid,
    input  logic                  lsu_resp_ready,
    output logic [DATA_WIDTH-1:0] lsu_resp_data,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic                  mem_req_wen,
    output logic [DATA_WIDTH-1:0] mem_req_wdata,
    output logic [MASK_WIDTH-1:0] mem_req_wmask,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_resp_data,
    output logic                  busy
);

    arb_state_e            state_q;
    logic                  init_q;
    logic                  owner_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  wen_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [MASK_WIDTH-1:0] wmask_q;
    logic [DATA_WIDTH-1:0] resp_data_q;
    logic                  mem_req_valid_q;
    logic                  ifu_resp_valid_q;
    logic                  lsu_resp_valid_q;

    logic       can_accept;
    logic [1:0] gnt;
    logic       gnt_owner;
    logic       accept;
    logic       resp_taken;

    // init_q keeps every ready low for the first cycle after reset release.
    assign can_accept = (state_q == ST_IDLE) && init_q;

    ysyx_23060201_mem_arb_grant u_grant (
`ifdef MEM_ARB_RR_EN
        .clk      (clk),
        .rst      (rst),
        .accept_i (accept),
`endif
        .ifu_req_i(ifu_req_valid && can_accept),
        .lsu_req_i(lsu_req_valid && can_accept),
        .gnt_o    (gnt),
        .owner_o  (gnt_owner)
    );

    assign accept        = |gnt;
    assign ifu_req_ready = gnt[0];
    assign lsu_req_ready = gnt[1];
    assign resp_taken    = (owner_q == OWNER_LSU) ? lsu_resp_ready : ifu_resp_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            init_q           <= 1'b0;
            owner_q          <= OWNER_IFU;
            addr_q           <= '0;
            wen_q            <= 1'b0;
            wdata_q          <= '0;
            wmask_q          <= '0;
            resp_data_q      <= '0;
            mem_req_valid_q  <= 1'b0;
            ifu_resp_valid_q <= 1'b0;
            lsu_resp_valid_q <= 1'b0;
        end else begin
            init_q <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        owner_q         <= gnt_owner;
                        mem_req_valid_q <= 1'b1;
                        state_q         <= ST_ISSUE;
                        if (gnt_owner == OWNER_LSU) begin
                            addr_q  <= lsu_req_addr;
                            wen_q   <= lsu_req_wen;
                            wdata_q <= lsu_req_wdata;
                            wmask_q <= lsu_req_wmask;
                        end else begin
                            addr_q  <= ifu_req_addr;
                            wen_q   <= 1'b0;
                            wdata_q <= '0;
                            wmask_q <= '0;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (mem_req_ready) begin
                        mem_req_valid_q <= 1'b0;
                        state_q         <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_resp_valid) begin
                        resp_data_q      <= mem_resp_data;
                        ifu_resp_valid_q <= (owner_q == OWNER_IFU);
                        lsu_resp_valid_q <= (owner_q == OWNER_LSU);
                        state_q          <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (resp_taken) begin
                        ifu_resp_valid_q <= 1'b0;
                        lsu_resp_valid_q <= 1'b0;
                        state_q          <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign mem_req_valid  = mem_req_valid_q;
    assign mem_req_addr   = addr_q;
    assign mem_req_wen    = wen_q;
    assign mem_req_wdata  = wdata_q;
    assign mem_req_wmask  = wmask_q;
    assign ifu_resp_valid = ifu_resp_valid_q;
    assign lsu_resp_valid = lsu_resp_valid_q;
    assign ifu_resp_data  = ifu_resp_valid_q ? resp_data_q : '0;
    assign lsu_resp_data  = lsu_resp_valid_q ? resp_data_q : '0;
    assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ysyx_23060201_mem_arbiter.sv
// Directed bench for the IFU/LSU memory arbiter; expectations follow MEM_ARB_RR_EN when defined.
module tb_ysyx_23060201_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready;
    logic [31:0] ifu_req_addr, ifu_resp_data;
    logic        lsu_req_valid, lsu_req_ready, lsu_req_wen, lsu_resp_valid, lsu_resp_ready;
    logic [31:0] lsu_req_addr, lsu_req_wdata, lsu_resp_data;
    logic [7:0]  lsu_req_wmask;
    logic        mem_req_valid, mem_req_ready, mem_req_wen, mem_resp_valid;
    logic [31:0] mem_req_addr, mem_req_wdata, mem_resp_data;
    logic [7:0]  mem_req_wmask;
    logic        busy;

    int n_chk  = 0;
    int n_pass = 0;

    ysyx_23060201_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_resp_data(ifu_resp_data),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
        .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_resp_data(lsu_resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Called in the accepting cycle; returns one step into RESP.
    task automatic serve(input int stall, input logic [31:0] d);
        mem_req_ready = 1'b0;
        step();
        repeat (stall) step();
        mem_req_ready = 1'b1;
        step();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = d;
        step();
        mem_resp_valid = 1'b0;
    endtask

    logic [2:0] exp_lsu_win;

    initial begin
`ifdef MEM_ARB_RR_EN
        exp_lsu_win = 3'b010;
`else
        exp_lsu_win = 3'b111;
`endif
        rst = 1'b1;
        ifu_req_valid = 0; ifu_req_addr = 0; ifu_resp_ready = 0;
        lsu_req_valid = 0; lsu_req_addr = 0; lsu_req_wen = 0; lsu_req_wdata = 0; lsu_req_wmask = 0;
        lsu_resp_ready = 0; mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = 0;

        // reset state
        step();
        ifu_req_valid = 1; lsu_req_valid = 1;
        step(); smp();
        check("rst_busy", busy, 0);
        check("rst_mem_req_valid", mem_req_valid, 0);
        check("rst_ifu_req_ready", ifu_req_ready, 0);
        check("rst_lsu_req_ready", lsu_req_ready, 0);
        check("rst_ifu_resp_valid", ifu_resp_valid, 0);
        check("rst_lsu_resp_valid", lsu_resp_valid, 0);
        step();
        rst = 0; lsu_req_valid = 0;
        ifu_req_valid = 1; ifu_req_addr = 32'h8000_0000;
        ifu_resp_ready = 1; lsu_resp_ready = 1;
        smp();
        check("post_release_ifu_ready", ifu_req_ready, 0);

        // IFU fetch
        step(); smp();
        check("fetch_ifu_ready", ifu_req_ready, 1);
        check("fetch_lsu_ready", lsu_req_ready, 0);
        step();
        ifu_req_valid = 0; mem_req_ready = 1;
        smp();
        check("fetch_mem_valid", mem_req_valid, 1);
        check("fetch_mem_addr", mem_req_addr, 32'h8000_0000);
        check("fetch_mem_wen", mem_req_wen, 0);
        check("fetch_busy", busy, 1);
        check("fetch_lsu_resp_issue", lsu_resp_valid, 0);
        step();
        mem_req_ready = 0; mem_resp_valid = 1; mem_resp_data = 32'h0000_0413;
        smp();
        check("fetch_wait_mem_valid", mem_req_valid, 0);
        check("fetch_wait_ifu_resp", ifu_resp_valid, 0);
        step();
        mem_resp_valid = 0; mem_resp_data = 0;
        smp();
        check("fetch_ifu_resp_valid", ifu_resp_valid, 1);
        check("fetch_ifu_resp_data", ifu_resp_data, 32'h0000_0413);
        check("fetch_lsu_resp_resp", lsu_resp_valid, 0);
        step(); smp();
        check("fetch_done_resp", ifu_resp_valid, 0);
        check("fetch_done_busy", busy, 0);

        // LSU store with a 3-cycle memory stall
        step();
        lsu_req_valid = 1; lsu_req_addr = 32'h8000_1004; lsu_req_wen = 1;
        lsu_req_wdata = 32'hDEAD_BEEF; lsu_req_wmask = 8'h0F;
        smp();
        check("st_lsu_ready", lsu_req_ready, 1);
        check("st_ifu_ready", ifu_req_ready, 0);
        step();
        lsu_req_valid = 0; lsu_req_addr = 0; lsu_req_wen = 0; lsu_req_wdata = 0; lsu_req_wmask = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_req_ready = 1;
            smp();
            check($sformatf("st_issue%0d_valid", i), mem_req_valid, 1);
            check($sformatf("st_issue%0d_addr", i), mem_req_addr, 32'h8000_1004);
            check($sformatf("st_issue%0d_wdata", i), mem_req_wdata, 32'hDEAD_BEEF);
            check($sformatf("st_issue%0d_wmask", i), mem_req_wmask, 8'h0F);
            check($sformatf("st_issue%0d_wen", i), mem_req_wen, 1);
            step();
        end
        mem_req_ready = 0;
        smp();
        check("st_wait_mem_valid", mem_req_valid, 0);
        check("st_wait_resp", lsu_resp_valid, 0);
        step();
        mem_resp_valid = 1; mem_resp_data = 32'hDEAD_BEEF;
        step();
        mem_resp_valid = 0;
        smp();
        check("st_ack_lsu", lsu_resp_valid, 1);
        check("st_ack_ifu", ifu_resp_valid, 0);
        step(); smp();
        check("st_ack_single_pulse", lsu_resp_valid, 0);

        // contention: both requesters valid every cycle
        step();
        ifu_req_valid = 1; ifu_req_addr = 32'h8000_0010;
        lsu_req_valid = 1; lsu_req_addr = 32'h8000_2000; lsu_req_wen = 0;
        for (int k = 0; k < 3; k++) begin
            smp();
            check($sformatf("cont%0d_lsu_ready", k), lsu_req_ready, exp_lsu_win[k]);
            check($sformatf("cont%0d_ifu_ready", k), ifu_req_ready, !exp_lsu_win[k]);
            serve(0, 32'h100 + k);
            smp();
            check($sformatf("cont%0d_lsu_resp", k), lsu_resp_valid, exp_lsu_win[k]);
            check($sformatf("cont%0d_ifu_resp", k), ifu_resp_valid, !exp_lsu_win[k]);
            check($sformatf("cont%0d_resp_ready_blocked", k), ifu_req_ready | lsu_req_ready, 0);
            step();
        end
        ifu_req_valid = 0; lsu_req_valid = 0;

        // response backpressure on a load
        step();
        lsu_req_valid = 1; lsu_req_addr = 32'h8000_3000; lsu_req_wen = 0; lsu_resp_ready = 0;
        smp();
        check("bp_lsu_ready", lsu_req_ready, 1);
        serve(1, 32'h1234_5678);
        lsu_req_valid = 0; ifu_req_valid = 1; ifu_req_addr = 32'h8000_0004;
        mem_resp_data = 32'hAAAA_AAAA;
        for (int i = 0; i < 5; i++) begin
            smp();
            check($sformatf("bp%0d_valid", i), lsu_resp_valid, 1);
            check($sformatf("bp%0d_data", i), lsu_resp_data, 32'h1234_5678);
            check($sformatf("bp%0d_no_accept", i), ifu_req_ready, 0);
            step();
        end
        lsu_resp_ready = 1;
        smp();
        check("bp_release_valid", lsu_resp_valid, 1);
        check("bp_release_no_accept", ifu_req_ready, 0);
        step(); smp();
        check("bp_after_valid", lsu_resp_valid, 0);
        check("bp_after_ifu_ready", ifu_req_ready, 1);
        serve(0, 32'h0000_0013);
        ifu_req_valid = 0;
        smp();
        check("bp_fetch_valid", ifu_resp_valid, 1);
        check("bp_fetch_data", ifu_resp_data, 32'h0000_0013);
        step(); smp();
        check("bp_fetch_idle", busy, 0);

        // reset while waiting for memory
        step();
        lsu_req_valid = 1; lsu_req_addr = 32'h8000_4000;
        step();
        lsu_req_valid = 0; mem_req_ready = 1;
        step();
        mem_req_ready = 0; ifu_req_valid = 1;
        smp();
        check("rw_busy_before", busy, 1);
        #2 rst = 1;
        #1;
        check("rw_busy", busy, 0);
        check("rw_mem_req_valid", mem_req_valid, 0);
        check("rw_ifu_req_ready", ifu_req_ready, 0);
        check("rw_lsu_resp_valid", lsu_resp_valid, 0);
        check("rw_ifu_resp_valid", ifu_resp_valid, 0);
        step(); step();
        rst = 0; ifu_req_valid = 0; mem_resp_valid = 1; mem_resp_data = 32'h5555_5555;
        smp();
        check("rw_late_busy", busy, 0);
        step();
        mem_resp_valid = 0;
        smp();
        check("rw_late_lsu_resp", lsu_resp_valid, 0);
        check("rw_late_ifu_resp", ifu_resp_valid, 0);
        check("rw_late_idle", busy, 0);

        // spurious memory response while idle
        step(); step();
        mem_resp_valid = 1; mem_resp_data = 32'hFFFF_FFFF;
        smp();
        check("sp_busy_during", busy, 0);
        step();
        mem_resp_valid = 0;
        smp();
        check("sp_lsu_resp", lsu_resp_valid, 0);
        check("sp_ifu_resp", ifu_resp_valid, 0);
        check("sp_busy", busy, 0);
        check("sp_mem_req_valid", mem_req_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
